// File: rtl/obi_pkg.sv
// OBI bus payload types shared by the external-bus guard and its neighbours.
//   obi_req_t  : req, we, be, addr, wdata   (master -> slave)
//   obi_resp_t : gnt, rvalid, rdata         (slave -> master)
package obi_pkg;

  localparam int unsigned OBI_AW  = 32;
  localparam int unsigned OBI_DW  = 32;
  localparam int unsigned OBI_BEW = OBI_DW / 8;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/gr_heep_ext_slave_guard.sv
// Per-port OBI guard between an external-bus slave port and its peripheral.
// Passes requests/responses through combinationally, caps the number of
// transactions in flight (pending + orphaned) and runs a watchdog on the
// oldest pending transaction. On expiry it answers the master with an error
// response and later swallows the slave's late response.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   master_req_i    request from the crossbar slave port
//   master_resp_o   response to the crossbar (gnt gated, rvalid forwarded or synthesized)
//   slave_req_o     request to the peripheral (req gated by the outstanding limit)
//   slave_resp_i    response from the peripheral
//   clear_i         clears timeout_o / timeout_addr_o at the next edge
//   timeout_o       sticky: at least one timeout since reset or clear
//   timeout_addr_o  address of the first timed-out transaction since reset or clear
module gr_heep_ext_slave_guard #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter logic [31:0] ERR_RDATA       = 32'hBADCAB1E
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  obi_pkg::obi_req_t  master_req_i,
  output obi_pkg::obi_resp_t master_resp_o,
  output obi_pkg::obi_req_t  slave_req_o,
  input  obi_pkg::obi_resp_t slave_resp_i,
  input  logic               clear_i,
  output logic               timeout_o,
  output logic [31:0]        timeout_addr_o
);

  localparam int unsigned AW    = obi_pkg::OBI_AW;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic [CNT_W-1:0] orph_cnt_q, orph_cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             timeout_q, timeout_d;
  logic [AW-1:0]    timeout_addr_q, timeout_addr_d;
  logic [AW-1:0]    fifo_q [MAX_OUTSTANDING];

  logic          can_acc;
  logic          push;
  logic          has_pend;
  logic          has_orph;
  logic          drop_orph;
  logic          fwd;
  logic          tmo;
  logic          pop;
  logic [AW-1:0] head_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Event decode: acceptance, response routing and watchdog expiry.
  always_comb begin
    can_acc   = (SUM_W'(pend_cnt_q) + SUM_W'(orph_cnt_q)) < SUM_W'(MAX_OUTSTANDING);
    push      = master_req_i.req & slave_resp_i.gnt & can_acc;
    has_pend  = (pend_cnt_q != '0);
    has_orph  = (orph_cnt_q != '0);
    // In-order responses: an rvalid belongs to the oldest orphan first.
    drop_orph = slave_resp_i.rvalid & has_orph;
    fwd       = slave_resp_i.rvalid & ~has_orph & has_pend;
    // A real response for the head in its last budget cycle beats the error.
    tmo       = has_pend & (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) & ~fwd;
    pop       = fwd | tmo;
    head_addr = fifo_q[rd_ptr_q];
  end

  // Zero-latency request/response paths.
  always_comb begin
    slave_req_o          = master_req_i;
    slave_req_o.req      = master_req_i.req & can_acc;
    master_resp_o.gnt    = slave_resp_i.gnt & can_acc;
    master_resp_o.rvalid = pop;
    master_resp_o.rdata  = tmo ? ERR_RDATA : slave_resp_i.rdata;
  end

  // Next-state for counters, pointers, watchdog and sticky status.
  always_comb begin
    pend_cnt_d     = pend_cnt_q;
    orph_cnt_d     = orph_cnt_q;
    timer_d        = timer_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    timeout_d      = timeout_q;
    timeout_addr_d = timeout_addr_q;

    if (push && !pop) begin
      pend_cnt_d = pend_cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      pend_cnt_d = pend_cnt_q - CNT_W'(1);
    end

    if (tmo && !drop_orph) begin
      orph_cnt_d = orph_cnt_q + CNT_W'(1);
    end else if (drop_orph && !tmo) begin
      orph_cnt_d = orph_cnt_q - CNT_W'(1);
    end

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Budget restarts whenever a new transaction becomes head.
    if (pop || !has_pend) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    // A timeout coinciding with clear_i is recorded as the new first one.
    if (tmo) begin
      timeout_d = 1'b1;
      if (!timeout_q || clear_i) begin
        timeout_addr_d = head_addr;
      end
    end else if (clear_i) begin
      timeout_d      = 1'b0;
      timeout_addr_d = '0;
    end
  end

  // Control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_cnt_q     <= '0;
      orph_cnt_q     <= '0;
      timer_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      timeout_q      <= 1'b0;
      timeout_addr_q <= '0;
    end else begin
      pend_cnt_q     <= pend_cnt_d;
      orph_cnt_q     <= orph_cnt_d;
      timer_q        <= timer_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      timeout_q      <= timeout_d;
      timeout_addr_q <= timeout_addr_d;
    end
  end

  // Address storage; contents are only read when pend_cnt is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= master_req_i.addr;
    end
  end

  assign timeout_o      = timeout_q;
  assign timeout_addr_o = timeout_addr_q;

endmodule

// File: tb/tb_gr_heep_ext_slave_guard.sv
// Bench for gr_heep_ext_slave_guard (MAX_OUTSTANDING=2, TIMEOUT_CYCLES=8).
// Directed vector table, hand sequences for multi-cycle corners, then random
// traffic; every cycle is also checked against a queue-based reference model.
module tb_gr_heep_ext_slave_guard;

  localparam int unsigned MAXO = 2;
  localparam int unsigned TMO  = 8;
  localparam logic [31:0] ERR  = 32'hBADCAB1E;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  obi_pkg::obi_req_t  m_req;
  obi_pkg::obi_resp_t m_resp;
  obi_pkg::obi_req_t  s_req;
  obi_pkg::obi_resp_t s_resp;
  logic               clr;
  logic               to_flag;
  logic [31:0]        to_addr;

  gr_heep_ext_slave_guard #(
    .MAX_OUTSTANDING(MAXO),
    .TIMEOUT_CYCLES (TMO),
    .ERR_RDATA      (ERR)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .master_req_i  (m_req),
    .master_resp_o (m_resp),
    .slave_req_o   (s_req),
    .slave_resp_i  (s_resp),
    .clear_i       (clr),
    .timeout_o     (to_flag),
    .timeout_addr_o(to_addr)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of pending addresses, orphan count, head deadline.
  logic [31:0] q_addr[$];
  int          m_orph = 0;
  logic        m_flag = 1'b0;
  logic [31:0] m_faddr = '0;
  int          m_deadline = 0;
  int          cyc_n = 0;

  // Last sampled DUT outputs.
  logic        act_gnt, act_rv, act_sreq, act_to;
  logic [31:0] act_rdata, act_toaddr;

  typedef struct {
    logic        mreq;
    logic [31:0] addr;
    logic        sgnt;
    logic        srv;
    logic [31:0] srdata;
    logic        e_gnt;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic        e_to;
    logic [31:0] e_toaddr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_addr.delete();
    m_orph  = 0;
    m_flag  = 1'b0;
    m_faddr = '0;
  endtask

  // Applies one cycle of stimulus at posedge+1, checks at posedge+3, advances.
  task automatic run_cycle(input logic mreq, input logic [31:0] addr, input logic sgnt,
                           input logic srv, input logic [31:0] srdata, input logic clr_v);
    int          sz;
    logic        can, fwd, drop_o, tmo, push;
    logic [31:0] e_rdata;
    m_req.req    = mreq;
    m_req.addr   = addr;
    m_req.we     = 1'($urandom);
    m_req.be     = 4'($urandom);
    m_req.wdata  = $urandom;
    s_resp.gnt   = sgnt;
    s_resp.rvalid = srv;
    s_resp.rdata = srdata;
    clr          = clr_v;
    #2;
    act_gnt    = m_resp.gnt;
    act_rv     = m_resp.rvalid;
    act_rdata  = m_resp.rdata;
    act_sreq   = s_req.req;
    act_to     = to_flag;
    act_toaddr = to_addr;

    sz      = q_addr.size();
    can     = (sz + m_orph) < int'(MAXO);
    fwd     = srv && (m_orph == 0) && (sz > 0);
    drop_o  = srv && (m_orph > 0);
    tmo     = (sz > 0) && (cyc_n == m_deadline) && !fwd;
    push    = mreq && sgnt && can;
    e_rdata = tmo ? ERR : srdata;

    chk("m_gnt", 32'(act_gnt), 32'(sgnt && can));
    chk("s_req", 32'(act_sreq), 32'(mreq && can));
    chk("s_addr", s_req.addr, addr);
    chk("s_wdata", s_req.wdata, m_req.wdata);
    chk("s_we_be", 32'({s_req.we, s_req.be}), 32'({m_req.we, m_req.be}));
    chk("m_rvalid", 32'(act_rv), 32'(fwd || tmo));
    if (fwd || tmo) chk("m_rdata", act_rdata, e_rdata);
    chk("timeout", 32'(act_to), 32'(m_flag));
    chk("timeout_addr", act_toaddr, m_faddr);

    if (tmo) begin
      if (!m_flag || clr_v) m_faddr = q_addr[0];
      m_flag = 1'b1;
    end else if (clr_v) begin
      m_flag  = 1'b0;
      m_faddr = '0;
    end
    if (drop_o) m_orph--;
    if (tmo) m_orph++;
    if (fwd || tmo) begin
      void'(q_addr.pop_front());
      if (q_addr.size() > 0) m_deadline = cyc_n + int'(TMO);
    end
    if (push) begin
      if (q_addr.size() == 0) m_deadline = cyc_n + int'(TMO);
      q_addr.push_back(addr);
    end
    cyc_n++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Answers everything outstanding so the next sequence starts empty.
  task automatic settle();
    for (int i = 0; i < 64; i++) begin
      if (q_addr.size() + m_orph == 0) break;
      run_cycle(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b0);
    end
    chk("settle_empty", 32'(q_addr.size() + m_orph), 32'd0);
  endtask

  task automatic add_vec(input logic mreq, input logic [31:0] addr, input logic sgnt,
                         input logic srv, input logic [31:0] rd, input logic eg,
                         input logic erv, input logic [31:0] erd, input logic eto,
                         input logic [31:0] eta);
    vec_t v;
    v.mreq = mreq; v.addr = addr; v.sgnt = sgnt; v.srv = srv; v.srdata = rd;
    v.e_gnt = eg; v.e_rv = erv; v.e_rdata = erd; v.e_to = eto; v.e_toaddr = eta;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Reset state, with inputs active to show the request path mirrors.
    m_req = '0; m_req.req = 1'b1; m_req.addr = 32'h2000_0000;
    s_resp = '0; s_resp.gnt = 1'b1; s_resp.rvalid = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    chk("rst_rvalid", 32'(m_resp.rvalid), 32'd0);
    chk("rst_sreq", 32'(s_req.req), 32'd1);
    chk("rst_gnt", 32'(m_resp.gnt), 32'd1);
    chk("rst_to", 32'(to_flag), 32'd0);
    chk("rst_toaddr", to_addr, 32'd0);
    m_req = '0; s_resp = '0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Directed table: normal read, then timeout with late response.
    //       mreq  addr          sgnt srv  rdata          gnt rv   rdata          to   toaddr
    add_vec(1'b1, 32'h2000_0010, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b0, 32'h0);
    add_vec(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b0, 32'h0);
    add_vec(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b0, 32'h0);
    add_vec(1'b0, 32'h0,         1'b0, 1'b1, 32'h1234,   1'b0, 1'b1, 32'h1234,   1'b0, 32'h0);
    add_vec(1'b1, 32'h2000_0020, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b0, 32'h0);
    for (int i = 1; i <= 7; i++)
      add_vec(1'b0, 32'h0,       1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b0, 32'h0);
    add_vec(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,      1'b0, 1'b1, ERR,        1'b0, 32'h0);
    for (int i = 9; i <= 11; i++)
      add_vec(1'b0, 32'h0,       1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b1, 32'h2000_0020);
    add_vec(1'b0, 32'h0,         1'b0, 1'b1, 32'hDEAD,   1'b0, 1'b0, 32'h0,      1'b1, 32'h2000_0020);
    // Orphan count back to 0: two accepted, third refused.
    add_vec(1'b1, 32'h2000_0060, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b1, 32'h2000_0020);
    add_vec(1'b1, 32'h2000_0064, 1'b1, 1'b0, 32'h0,      1'b1, 1'b0, 32'h0,      1'b1, 32'h2000_0020);
    add_vec(1'b1, 32'h2000_0068, 1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 32'h0,      1'b1, 32'h2000_0020);

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i].mreq, vecs[i].addr, vecs[i].sgnt, vecs[i].srv, vecs[i].srdata, 1'b0);
      chk($sformatf("vec%0d_gnt", i), 32'(act_gnt), 32'(vecs[i].e_gnt));
      chk($sformatf("vec%0d_rv", i), 32'(act_rv), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d_rdata", i), act_rdata, vecs[i].e_rdata);
      chk($sformatf("vec%0d_to", i), 32'(act_to), 32'(vecs[i].e_to));
      chk($sformatf("vec%0d_toaddr", i), act_toaddr, vecs[i].e_toaddr);
    end
    settle();
    run_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Back-to-back with an always-granting, silent slave.
    run_cycle(1'b1, 32'h2000_0100, 1'b1, 1'b0, '0, 1'b0);
    chk("bb_gnt0", 32'(act_gnt), 32'd1);
    run_cycle(1'b1, 32'h2000_0104, 1'b1, 1'b0, '0, 1'b0);
    chk("bb_gnt1", 32'(act_gnt), 32'd1);
    for (int c = 2; c <= 12; c++) begin
      run_cycle(1'b1, 32'h2000_0108, 1'b1, 1'b0, '0, 1'b0);
      chk($sformatf("bb_blk_gnt_c%0d", c), 32'(act_gnt), 32'd0);
      chk($sformatf("bb_blk_req_c%0d", c), 32'(act_sreq), 32'd0);
      if (c == 8) begin
        chk("bb_err_rv", 32'(act_rv), 32'd1);
        chk("bb_err_rdata", act_rdata, ERR);
      end
    end
    settle();
    run_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Real response in the very last budget cycle wins.
    run_cycle(1'b1, 32'h2000_0200, 1'b1, 1'b0, '0, 1'b0);
    idle(7);
    run_cycle(1'b0, '0, 1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
    chk("edge_rv", 32'(act_rv), 32'd1);
    chk("edge_rdata", act_rdata, 32'h5555_AAAA);
    idle(1);
    chk("edge_to", 32'(act_to), 32'd0);

    // Two timeouts keep the first address; clear then a third timeout.
    run_cycle(1'b1, 32'h2000_0030, 1'b1, 1'b0, '0, 1'b0);
    run_cycle(1'b1, 32'h2000_0040, 1'b1, 1'b0, '0, 1'b0);
    for (int c = 2; c <= 16; c++) begin
      run_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      if (c == 8 || c == 16) chk($sformatf("two_err_c%0d", c), 32'(act_rv), 32'd1);
    end
    idle(1);
    chk("two_to", 32'(act_to), 32'd1);
    chk("two_toaddr", act_toaddr, 32'h2000_0030);
    settle();
    run_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    run_cycle(1'b1, 32'h2000_0050, 1'b1, 1'b0, '0, 1'b0);
    chk("clr_to", 32'(act_to), 32'd0);
    idle(8);
    idle(1);
    chk("third_to", 32'(act_to), 32'd1);
    chk("third_toaddr", act_toaddr, 32'h2000_0050);
    settle();

    // Asynchronous reset with two transactions pending.
    run_cycle(1'b1, 32'h2000_0300, 1'b1, 1'b0, '0, 1'b0);
    run_cycle(1'b1, 32'h2000_0304, 1'b1, 1'b0, '0, 1'b0);
    m_req.req = 1'b1; m_req.addr = 32'h2000_0308;
    s_resp.gnt = 1'b1; s_resp.rvalid = 1'b1; s_resp.rdata = 32'h1111_2222;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mrst_rvalid", 32'(m_resp.rvalid), 32'd0);
    chk("mrst_sreq", 32'(s_req.req), 32'd1);
    chk("mrst_gnt", 32'(m_resp.gnt), 32'd1);
    chk("mrst_to", 32'(to_flag), 32'd0);
    chk("mrst_toaddr", to_addr, 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    run_cycle(1'b0, '0, 1'b0, 1'b1, 32'hABCD_0000, 1'b0);
    chk("stray_dropped", 32'(act_rv), 32'd0);
    run_cycle(1'b1, 32'h2000_0070, 1'b1, 1'b0, '0, 1'b0);
    chk("post_gnt", 32'(act_gnt), 32'd1);
    run_cycle(1'b0, '0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
    chk("post_rv", 32'(act_rv), 32'd1);
    chk("post_rdata", act_rdata, 32'hCAFE_F00D);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic srv_r;
      srv_r = 1'b0;
      if ((q_addr.size() + m_orph) > 0 && $urandom_range(99) < 25) srv_r = 1'b1;
      run_cycle($urandom_range(99) < 60, $urandom, $urandom_range(99) < 70,
                srv_r, $urandom, $urandom_range(99) < 3);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
